// File: rtl/fetch_decode_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one request outstanding to
// instruction memory and buffers returned words (with their PC) for the decoder.
//
// Handshakes:
//   imem: a request transfers in a cycle with imem_req && imem_gnt; exactly one
//         imem_rvalid answers each granted request, at least one cycle later.
//   dec:  the head entry transfers in a cycle with dec_valid && dec_ready;
//         dec_valid never depends on dec_ready.
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int               PTR_W   = $clog2(BUF_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      buf_inst_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q   [BUF_DEPTH];

    logic fire;
    logic push;
    logic pop;

    assign imem_req  = (state_q == FETCH) && (count_q < DEPTH_C) && !rst;
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;

    // Only a response to a live request in WAIT is kept; DRAIN swallows stale ones.
    assign push      = (state_q == WAIT) && imem_rvalid && !redirect_valid;

    assign dec_valid = (count_q != '0);
    assign pop       = dec_valid && dec_ready;
    assign dec_inst  = dec_valid ? buf_inst_q[rd_ptr_q] : NOP;
    assign dec_pc    = dec_valid ? buf_pc_q[rd_ptr_q]   : 32'h0000_0000;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (fire) begin
                    state_d = redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (fire && !redirect_valid) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A redirect empties the buffer even if a pop completed this cycle.
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            buf_inst_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: directed scenarios followed by a randomized run,
// all checked against a PC-stream model of what memory and the decoder should see.
module tb_fetch_decode_ctrl;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_pc;

  logic        w_req, w_rvalid, w_dec_valid;
  logic [31:0] w_addr, w_rdata, w_dec_inst, w_dec_pc;
  logic        w_gnt = 1'b1;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_dec_ready = 1'b1;

  fetch_decode_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  fetch_decode_ctrl #(.RESET_PC(WRAP_PC), .BUF_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .dec_valid(w_dec_valid), .dec_inst(w_dec_inst), .dec_pc(w_dec_pc), .dec_ready(w_dec_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder state
  bit          pend = 0, stale = 0, rand_mode = 0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  int          gnt_mode = 0;
  int          mem_lat = 1;
  bit          w_pend = 0;
  logic [31:0] w_pend_addr = '0;

  // reference model: next PC the decoder must see, next address memory must see
  logic [31:0] exp_pc, fetch_exp, prev_addr;
  bit          prev_hold = 0;

  logic [31:0] gnt_q[$], pop_q[$], w_gnt_q[$], w_pop_q[$], w_popi_q[$];
  logic        s_req, s_dvalid;
  logic [31:0] s_addr, s_dpc, s_dinst;
  int          first_req, first_dec;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory side, sample at #1 after negedge, update model, advance.
  task automatic cycle();
    bit was_pend, was_stale;
    was_pend  = pend;
    was_stale = stale;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend  = 0;
        stale = 0;
      end else begin
        pend_wait--;
      end
    end
    if (gnt_mode == 2) imem_gnt = ($urandom_range(0, 3) != 0);
    else imem_gnt = (gnt_mode == 1);
    w_rvalid = w_pend;
    w_rdata  = mem_word(w_pend_addr);
    w_pend   = 0;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    s_dvalid = dec_valid; s_dpc = dec_pc; s_dinst = dec_inst;
    if (w_req) begin
      w_pend = 1; w_pend_addr = w_addr; w_gnt_q.push_back(w_addr);
    end
    if (w_dec_valid && !rst) begin
      w_pop_q.push_back(w_dec_pc); w_popi_q.push_back(w_dec_inst);
    end
    if (rst) begin
      check("rst_req_low", {31'b0, imem_req}, 32'd0);
      exp_pc = RST_PC; fetch_exp = RST_PC;
      if (pend) stale = 1;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("addr_hold_req", {31'b0, imem_req}, 32'd1);
        check("addr_hold", imem_addr, prev_addr);
      end
      if (was_pend && !was_stale) check("one_outstanding", {31'b0, imem_req}, 32'd0);
      if (!dec_valid) begin
        check("idle_inst_nop", dec_inst, NOP);
        check("idle_pc_zero", dec_pc, 32'd0);
      end else if (dec_ready && !redirect_valid) begin
        check("dec_pc", dec_pc, exp_pc);
        check("dec_inst", dec_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pop_q.push_back(dec_pc);
      end
      if (imem_req && imem_gnt) begin
        check("fetch_addr", imem_addr, fetch_exp);
        pend = 1; stale = 0; pend_addr = imem_addr;
        pend_wait = rand_mode ? $urandom_range(0, 2) : mem_lat - 1;
        gnt_q.push_back(imem_addr);
        fetch_exp = fetch_exp + 32'd4;
      end
      if (redirect_valid) begin
        fetch_exp = {redirect_pc[31:2], 2'b00};
        exp_pc    = {redirect_pc[31:2], 2'b00};
      end
      prev_hold = imem_req && !imem_gnt && !redirect_valid;
      prev_addr = imem_addr;
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    gnt_q.delete(); pop_q.delete();
    w_gnt_q.delete(); w_pop_q.delete(); w_popi_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
    w_rvalid = 0; w_rdata = '0;
    exp_pc = RST_PC; fetch_exp = RST_PC; prev_addr = '0;
    @(negedge clk);

    // reset state
    cycle();
    check("reset_dec_valid", {31'b0, s_dvalid}, 32'd0);
    check("reset_dec_inst", s_dinst, NOP);
    check("reset_dec_pc", s_dpc, 32'd0);
    rst = 1'b0; clear_logs();

    // streaming with zero-wait memory
    dec_ready = 1; gnt_mode = 1; mem_lat = 1;
    first_req = -1; first_dec = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_req && first_req < 0) first_req = i;
      if (s_dvalid && first_dec < 0) first_dec = i;
    end
    check("first_dec_latency", 32'(first_dec - first_req), 32'd2);
    check("stream_grants", 32'(gnt_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("stream_addr", qget(gnt_q, i), 32'(i * 4));

    // decoder stall fills the buffer and stops fetching
    do_reset();
    dec_ready = 0;
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_req_low", {31'b0, s_req}, 32'd0);
      check("stall_head_inst", s_dinst, mem_word(32'd0));
      check("stall_head_pc", s_dpc, 32'd0);
    end
    check("stall_grants", 32'(gnt_q.size()), 32'd2);
    gnt_q.delete();
    dec_ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    check("unstall_pop0", qget(pop_q, 0), 32'd0);
    check("unstall_pop1", qget(pop_q, 1), 32'd4);
    check("unstall_resume", qget(gnt_q, 0), 32'd8);

    // redirect while waiting on a slow response
    do_reset();
    mem_lat = 3;
    cycle();
    redirect_valid = 1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 0; mem_lat = 1;
    gnt_q.delete(); pop_q.delete();
    for (int i = 0; i < 8; i++) cycle();
    check("redir_wait_addr", qget(gnt_q, 0), 32'h0000_0100);
    check("redir_wait_first_pc", qget(pop_q, 0), 32'h0000_0100);
    for (int i = 0; i < pop_q.size(); i++)
      check("redir_wait_no_old", {31'b0, pop_q[i] >= 32'h100}, 32'd1);

    // redirect in the same cycle the fetch of 0x8 is granted
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    redirect_valid = 1; redirect_pc = 32'h0000_0040;
    cycle();
    check("redir_gnt_req", {31'b0, s_req}, 32'd1);
    check("redir_gnt_addr", s_addr, 32'h0000_0008);
    redirect_valid = 0;
    gnt_q.delete(); pop_q.delete();
    cycle();
    check("drain_no_req", {31'b0, s_req}, 32'd0);
    cycle();
    check("drain_next_req", {31'b0, s_req}, 32'd1);
    check("drain_next_addr", s_addr, 32'h0000_0040);
    for (int i = 0; i < 4; i++) cycle();
    check("drain_first_pc", qget(pop_q, 0), 32'h0000_0040);

    // PC wrap from the top of the address space
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    check("wrap_addr0", qget(w_gnt_q, 0), WRAP_PC);
    check("wrap_addr1", qget(w_gnt_q, 1), 32'h0000_0000);
    check("wrap_pop_pc0", qget(w_pop_q, 0), WRAP_PC);
    check("wrap_pop_inst0", qget(w_popi_q, 0), mem_word(WRAP_PC));
    check("wrap_pop_pc1", qget(w_pop_q, 1), 32'h0000_0000);

    // reset while waiting, response lands after reset
    do_reset();
    mem_lat = 2;
    cycle();
    rst = 1;
    cycle();
    rst = 0; gnt_mode = 0;
    cycle();
    check("rst_wait_no_valid_a", {31'b0, s_dvalid}, 32'd0);
    cycle();
    check("rst_wait_no_valid_b", {31'b0, s_dvalid}, 32'd0);
    check("rst_wait_req", {31'b0, s_req}, 32'd1);
    check("rst_wait_addr", s_addr, RST_PC);
    gnt_mode = 1; mem_lat = 1;
    clear_logs();
    for (int i = 0; i < 4; i++) cycle();
    check("rst_wait_first_pc", qget(pop_q, 0), RST_PC);

    // randomized traffic
    rand_mode = 1; gnt_mode = 2;
    pop_q.delete();
    for (int i = 0; i < 3000; i++) begin
      dec_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; redirect_valid = 0;
    check("rand_progress", {31'b0, pop_q.size() > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
Instruction-fetch sequencer feeding the instruction decoder. It owns the PC and issues single-outstanding requests to instruction memory with a req/gnt/rvalid handshake. Returned words are buffered with their PC in a small FIFO and presented to the decoder with a valid/ready handshake. Branch/jump redirects flush the buffer and discard any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid (>=1 cycle after gnt)
imem_rdata  in  32  instruction word
redirect_valid  in  1  branch/jump taken
redirect_pc  in  32  new fetch PC
dec_valid  out  1  buffer head valid, to decoder
dec_inst  out  32  instruction to decoder instruction input
dec_pc  out  32  PC of dec_inst
dec_ready  in  1  decoder consumes head

Behaviour:
- One clock; reset is synchronous and active-high. Ports named clk and rst.
- Reset, including mid-transaction: state=FETCH, pc=RESET_PC, buffer empty, imem_req=0 during the reset cycle, dec_valid=0, dec_inst=32'h0000_0013 (NOP), dec_pc=0. A response arriving after reset is ignored, because the state is not WAIT.
- States: FETCH, WAIT, DRAIN.
- Outputs:
  - imem_req = (state==FETCH) && (count<BUF_DEPTH) && !rst.
  - imem_addr = pc.
  - dec_valid = (count!=0).
  - dec_inst/dec_pc = head entry when valid, otherwise NOP/0.
- FETCH:
  - req && gnt && !redirect_valid: req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), go to WAIT.
  - req && gnt && redirect_valid: the granted request is stale; pc<=redirect_pc, go to DRAIN.
  - !gnt: stay. Address is held stable while req is high and ungranted, except on redirect, which may change the address next cycle.
- WAIT:
  - rvalid && !redirect_valid: push {req_pc, rdata}, go to FETCH.
  - rvalid && redirect_valid: drop the data, go to FETCH.
  - !rvalid && redirect_valid: go to DRAIN.
- DRAIN: on rvalid, drop the data and go to FETCH. Redirect in DRAIN only updates pc.
- Redirect, any state:
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - Buffer flushed (count=0) at the end of the cycle.
  - A dec_valid&&dec_ready pop in the same cycle still completes; the consumer discards it.
- Buffer:
  - Push on accepted response, pop on dec_valid&&dec_ready.
  - Simultaneous push and pop keeps count unchanged.
  - No push when full can occur, because a request is only issued with count<BUF_DEPTH and count never increases while in WAIT.
- Latency: req in cycle N, gnt in N, rvalid in N+1 → dec_valid in N+2. Steady-state throughput is 1 instruction per 2 cycles at zero memory wait.
- Only one request outstanding at any time.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt, memory word=addr ^ 32'hA5A5_0000, dec_ready=1:
  - imem_addr sequence is 0,4,8,…
  - dec_pc/dec_inst match, first dec_valid 2 cycles after the first req.
- dec_ready=0:
  - After 2 pushes, imem_req drops and stays 0.
  - dec_inst holds entry 0.
  - Raising dec_ready yields PCs 0,4 in order, then fetching resumes at 8.
- Redirect to 32'h0000_0103 while in WAIT (rvalid delayed 3 cycles):
  - The late response is dropped.
  - The next req address is 32'h0000_0100.
  - No dec_valid with a PC other than 0x100 and later.
- Redirect in the same cycle as gnt for PC 0x8:
  - State goes to DRAIN.
  - The response for 0x8 is never presented; the next req is redirect_pc.
- RESET_PC=32'hFFFF_FFFC: after the fetch of 0xFFFF_FFFC, the next imem_addr is 0x0000_0000.
- rst asserted in WAIT with rvalid arriving the cycle after:
  - No push occurs, dec_valid stays 0.
  - The next req address is RESET_PC.
